eth_ipv4_addr_regs: RTL and testbench
=====================================

// Module: eth_ipv4_addr_regs
//
// PURPOSE
//   Register file and status block for the UDP/IPv4 CHDR transport. Holds NUM_SLOTS
//   {MAC, IP, UDP port} address slots, one of which is selected as active.
//   Drives my_mac/my_ip/my_udp_chdr_port into the Ethernet CHDR adapter.
//   Keeps NUM_CNT saturating, clear-on-read drop/event counters.
//   Inputs arrive already in bus_clk; CDC of drop events stays outside.
//
// PARAMETERS
//   NUM_SLOTS    2              number of address slots (1..8)
//   NUM_CNT      2              number of event counters (1..16)
//   CNT_W        32             counter width (8..32), saturating
//   REG_AWIDTH   14             register address width (byte addresses)
//   BASE         0              base byte address of this block
//   DEFAULT_MAC  48'h00802f16c52f  reset MAC for every slot
//   DEFAULT_IP   32'hC0A80A02   reset IP for every slot (192.168.10.2)
//   DEFAULT_UDP  16'd49153      reset UDP port for every slot
//
// PORTS
//   bus_clk           in   1            clock
//   bus_rst           in   1            reset: asynchronous, active-high
//   reg_wr_req        in   1            write strobe
//   reg_wr_addr       in   REG_AWIDTH   write address
//   reg_wr_data       in   32           write data
//   reg_rd_req        in   1            read strobe
//   reg_rd_addr       in   REG_AWIDTH   read address
//   reg_rd_resp       out  1            read response pulse
//   reg_rd_data       out  32           read data
//   cnt_evt           in   NUM_CNT      per-counter increment pulse, 1 per cycle max
//   my_mac            out  48           active slot MAC (registered)
//   my_ip             out  32           active slot IP (registered)
//   my_udp_chdr_port  out  16           active slot UDP port (registered)
//   active_slot       out  $clog2(NUM_SLOTS) (min 1)  selected slot index
//   addr_update       out  1            1-cycle pulse when any my_* output changes
//
// BEHAVIOUR
//   Map (offset from BASE): slot s at s*0x10: +0x0 MAC_LSB, +0x4 MAC_MSB[15:0],
//     +0x8 IP, +0xC UDP[15:0].
//   Global region G = NUM_SLOTS*0x10: G+0x0 ACTIVE_SLOT, G+0x4 COMMIT (write-only),
//     G+0x8+4*i CNT[i].
//   Reset: all slots at defaults; active_slot=0; my_* = defaults.
//     Counters=0; reg_rd_resp=0; reg_rd_data=0; addr_update=0.
//   Write: takes effect on the next edge. An ACTIVE_SLOT value >= NUM_SLOTS is ignored.
//   my_* are registered from the selected slot: 1-cycle latency after the relevant write.
//     addr_update pulses in the cycle the new value appears; no pulse if the value is unchanged.
//   Read: reg_rd_resp is high exactly 1 cycle after reg_rd_req, for 1 cycle.
//     Every address responds; unmapped and COMMIT read 32'h0.
//     Counters are zero-extended to 32 bits.
//   Write and read to the same address in the same cycle: the read returns the old value.
//   Counters: +1 per cnt_evt cycle; hold at 2^CNT_W-1.
//     A read clears the counter after the value is captured.
//     Read clear and event in the same cycle: the counter becomes 1 (no event lost).
//   Async reset mid-operation: all state returns to reset values immediately.
//     A pending read response is dropped.
//
// CONFIGURATION
//   ETH_IPV4_ADDR_ATOMIC_COMMIT_EN defined:
//     Slot writes go to shadow registers; slot reads return shadow values.
//     A COMMIT write copies the shadow of every slot whose bit is set in
//       wr_data[NUM_SLOTS-1:0] into the live slot.
//     The new my_* appears one cycle after the commit.
//     MAC LSB/MSB therefore never update separately.
//   Undefined: no shadows; slot writes go live directly; COMMIT writes are ignored.
//
// STRUCTURE
//   eth_ipv4_pkg: register offsets, DEFAULT_* values.
//     Also holds typedef struct packed {mac[47:0]; ip[31:0]; udp[15:0];} eth_addr_slot_t.
//   Sub-module eth_event_counter (CNT_W): saturating clear-on-read counter,
//     instantiated NUM_CNT times.
//
// TESTING
//   1. Reset, read slot0 MAC_LSB/MSB -> 32'h2f16c52f, 32'h00000080; resp 1 cycle after req.
//   2. Write slot1 IP=32'h0A000001, ACTIVE_SLOT=1.
//      -> my_ip=32'h0A000001 next cycle, addr_update one pulse.
//      ACTIVE_SLOT=5 (NUM_SLOTS=2) -> ignored.
//   3. CNT_W=8, 300 cnt_evt[0] pulses -> CNT0 reads 255; a second read returns 0.
//   4. CNT1=7, read in the same cycle as cnt_evt[1] -> reads 7, next read returns 1.
//   5. With the macro: write slot0 MAC_LSB -> my_mac unchanged.
//      COMMIT=1 -> my_mac updated one cycle later.
//      Without the macro: my_mac changes immediately.
//   6. Read unmapped offset -> resp=1, data=0.
//      Assert bus_rst during a pending read -> no resp; outputs at defaults.

Source files
------------

// File: rtl/eth_ipv4_pkg.sv
// Shared register map offsets, default addresses and the address slot record
// for the UDP/IPv4 CHDR transport address register block.
package eth_ipv4_pkg;

   localparam logic [47:0] DEFAULT_MAC = 48'h00802f16c52f;
   localparam logic [31:0] DEFAULT_IP  = 32'hC0A80A02;
   localparam logic [15:0] DEFAULT_UDP = 16'd49153;

   // Byte offsets inside one slot, and the slot stride
   localparam int OFF_MAC_LSB = 'h0;
   localparam int OFF_MAC_MSB = 'h4;
   localparam int OFF_IP      = 'h8;
   localparam int OFF_UDP     = 'hC;
   localparam int SLOT_STRIDE = 'h10;

   // Byte offsets inside the global region that follows the slots
   localparam int OFF_ACTIVE  = 'h0;
   localparam int OFF_COMMIT  = 'h4;
   localparam int OFF_CNT     = 'h8;

   typedef struct packed {
      logic [47:0] mac;
      logic [31:0] ip;
      logic [15:0] udp;
   } eth_addr_slot_t;

endpackage

// File: rtl/eth_event_counter.sv
// Saturating event counter with clear-on-read; an event arriving in the clear
// cycle is kept, so the counter restarts at 1 rather than 0.
module eth_event_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             evt_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = evt_i ? CNT_W'(1) : '0;
      end else if (evt_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_ipv4_addr_regs.sv
// Address slot register file, active-slot selection and event counters.
// Define ETH_IPV4_ADDR_ATOMIC_COMMIT_EN to stage slot writes in shadows until COMMIT.
module eth_ipv4_addr_regs #(
   parameter int          NUM_SLOTS   = 2,
   parameter int          NUM_CNT     = 2,
   parameter int          CNT_W       = 32,
   parameter int          REG_AWIDTH  = 14,
   parameter int          BASE        = 0,
   parameter logic [47:0] DEFAULT_MAC = eth_ipv4_pkg::DEFAULT_MAC,
   parameter logic [31:0] DEFAULT_IP  = eth_ipv4_pkg::DEFAULT_IP,
   parameter logic [15:0] DEFAULT_UDP = eth_ipv4_pkg::DEFAULT_UDP
) (
   input  logic                  bus_clk,
   input  logic                  bus_rst,
   input  logic                  reg_wr_req,
   input  logic [REG_AWIDTH-1:0] reg_wr_addr,
   input  logic [31:0]           reg_wr_data,
   input  logic                  reg_rd_req,
   input  logic [REG_AWIDTH-1:0] reg_rd_addr,
   output logic                  reg_rd_resp,
   output logic [31:0]           reg_rd_data,
   input  logic [NUM_CNT-1:0]    cnt_evt,
   output logic [47:0]           my_mac,
   output logic [31:0]           my_ip,
   output logic [15:0]           my_udp_chdr_port,
   output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] active_slot,
   output logic                  addr_update
);

   import eth_ipv4_pkg::*;

   localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [REG_AWIDTH-1:0] BASE_A   = REG_AWIDTH'(BASE);
   localparam logic [REG_AWIDTH-1:0] G_A      = REG_AWIDTH'(NUM_SLOTS * SLOT_STRIDE);
   localparam logic [REG_AWIDTH-1:0] ACTIVE_A = REG_AWIDTH'(NUM_SLOTS * SLOT_STRIDE + OFF_ACTIVE);
   localparam logic [REG_AWIDTH-1:0] COMMIT_A = REG_AWIDTH'(NUM_SLOTS * SLOT_STRIDE + OFF_COMMIT);
   localparam eth_addr_slot_t DEF_SLOT = '{mac: DEFAULT_MAC, ip: DEFAULT_IP, udp: DEFAULT_UDP};

   eth_addr_slot_t slot_q [NUM_SLOTS];
   eth_addr_slot_t slot_d [NUM_SLOTS];
   eth_addr_slot_t rd_src [NUM_SLOTS];
   eth_addr_slot_t my_q, my_d;
   logic [AW-1:0]  active_q, active_d;
   logic           addr_update_q;
   logic           rd_resp_q;
   logic [31:0]    rd_data_q;
   logic [31:0]    rd_val;

   // Offsets relative to BASE; only word-aligned addresses at or above BASE decode
   logic [REG_AWIDTH-1:0] wr_off, rd_off;
   logic                  wr_in, rd_in;
   logic [AW-1:0]         wr_slot, rd_slot;

   assign wr_off  = reg_wr_addr - BASE_A;
   assign rd_off  = reg_rd_addr - BASE_A;
   assign wr_in   = (reg_wr_addr >= BASE_A) && (reg_wr_addr[1:0] == 2'b00);
   assign rd_in   = (reg_rd_addr >= BASE_A) && (reg_rd_addr[1:0] == 2'b00);
   assign wr_slot = wr_off[AW+3:4];
   assign rd_slot = rd_off[AW+3:4];

`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
   eth_addr_slot_t shadow_q [NUM_SLOTS];
   eth_addr_slot_t shadow_d [NUM_SLOTS];

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= DEF_SLOT;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   always_comb begin
      slot_d   = slot_q;
      active_d = active_q;
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
      shadow_d = shadow_q;
`endif
      if (reg_wr_req && wr_in) begin
         if (wr_off < G_A) begin
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
            case (wr_off[3:2])
               2'd0:    shadow_d[wr_slot].mac[31:0]  = reg_wr_data;
               2'd1:    shadow_d[wr_slot].mac[47:32] = reg_wr_data[15:0];
               2'd2:    shadow_d[wr_slot].ip         = reg_wr_data;
               default: shadow_d[wr_slot].udp        = reg_wr_data[15:0];
            endcase
`else
            case (wr_off[3:2])
               2'd0:    slot_d[wr_slot].mac[31:0]  = reg_wr_data;
               2'd1:    slot_d[wr_slot].mac[47:32] = reg_wr_data[15:0];
               2'd2:    slot_d[wr_slot].ip         = reg_wr_data;
               default: slot_d[wr_slot].udp        = reg_wr_data[15:0];
            endcase
`endif
         end else if (wr_off == ACTIVE_A) begin
            if (reg_wr_data < 32'(NUM_SLOTS)) active_d = reg_wr_data[AW-1:0];
         end else if (wr_off == COMMIT_A) begin
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
            for (int i = 0; i < NUM_SLOTS; i++) begin
               if (reg_wr_data[i]) slot_d[i] = shadow_q[i];
            end
`endif
         end
      end
   end

   // Outputs follow the next-state selection so they land one cycle after the write
   assign my_d = slot_d[active_d];

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= DEF_SLOT;
         active_q      <= '0;
         my_q          <= DEF_SLOT;
         addr_update_q <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         active_q      <= active_d;
         my_q          <= my_d;
         addr_update_q <= (my_d != my_q);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_rd_src
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
         assign rd_src[gi] = shadow_q[gi];
`else
         assign rd_src[gi] = slot_q[gi];
`endif
      end
   endgenerate

   logic [NUM_CNT-1:0]            cnt_hit;
   logic [NUM_CNT-1:0][CNT_W-1:0] cnt_val;

   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         assign cnt_hit[gi] = rd_in &&
            (rd_off == REG_AWIDTH'(NUM_SLOTS * SLOT_STRIDE + OFF_CNT + 4 * gi));
         eth_event_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (bus_clk),
            .rst_i (bus_rst),
            .evt_i (cnt_evt[gi]),
            .clr_i (reg_rd_req && cnt_hit[gi]),
            .cnt_o (cnt_val[gi])
         );
      end
   endgenerate

   // Read mux sees pre-write state, so a same-cycle write is not visible yet
   always_comb begin
      rd_val = '0;
      if (rd_in && (rd_off < G_A)) begin
         case (rd_off[3:2])
            2'd0:    rd_val = rd_src[rd_slot].mac[31:0];
            2'd1:    rd_val = {16'h0, rd_src[rd_slot].mac[47:32]};
            2'd2:    rd_val = rd_src[rd_slot].ip;
            default: rd_val = {16'h0, rd_src[rd_slot].udp};
         endcase
      end else if (rd_in && (rd_off == ACTIVE_A)) begin
         rd_val = 32'(active_q);
      end
      for (int i = 0; i < NUM_CNT; i++) begin
         if (cnt_hit[i]) rd_val = 32'(cnt_val[i]);
      end
   end

   always_ff @(posedge bus_clk or posedge bus_rst) begin
      if (bus_rst) begin
         rd_resp_q <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_resp_q <= reg_rd_req;
         rd_data_q <= reg_rd_req ? rd_val : '0;
      end
   end

   assign reg_rd_resp      = rd_resp_q;
   assign reg_rd_data      = rd_data_q;
   assign my_mac           = my_q.mac;
   assign my_ip            = my_q.ip;
   assign my_udp_chdr_port = my_q.udp;
   assign active_slot      = active_q;
   assign addr_update      = addr_update_q;

endmodule

// File: tb/tb_eth_ipv4_addr_regs.sv
// Randomized and directed bench for eth_ipv4_addr_regs (NUM_SLOTS=2, NUM_CNT=2,
// CNT_W=8) with a behavioural model of the register map.
module tb_eth_ipv4_addr_regs;

   localparam int NS  = 2;
   localparam int NC  = 2;
   localparam int CW  = 8;
   localparam int AWD = 14;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [47:0] D_MAC = 48'h00802f16c52f;
   localparam logic [31:0] D_IP  = 32'hC0A80A02;
   localparam logic [15:0] D_UDP = 16'd49153;

   logic            bus_clk = 1'b0;
   logic            bus_rst;
   logic            reg_wr_req;
   logic [AWD-1:0]  reg_wr_addr;
   logic [31:0]     reg_wr_data;
   logic            reg_rd_req;
   logic [AWD-1:0]  reg_rd_addr;
   logic            reg_rd_resp;
   logic [31:0]     reg_rd_data;
   logic [NC-1:0]   cnt_evt;
   logic [47:0]     my_mac;
   logic [31:0]     my_ip;
   logic [15:0]     my_udp_chdr_port;
   logic [0:0]      active_slot;
   logic            addr_update;

   eth_ipv4_addr_regs #(
      .NUM_SLOTS (NS),
      .NUM_CNT   (NC),
      .CNT_W     (CW),
      .REG_AWIDTH(AWD),
      .BASE      (0)
   ) dut (
      .bus_clk          (bus_clk),
      .bus_rst          (bus_rst),
      .reg_wr_req       (reg_wr_req),
      .reg_wr_addr      (reg_wr_addr),
      .reg_wr_data      (reg_wr_data),
      .reg_rd_req       (reg_rd_req),
      .reg_rd_addr      (reg_rd_addr),
      .reg_rd_resp      (reg_rd_resp),
      .reg_rd_data      (reg_rd_data),
      .cnt_evt          (cnt_evt),
      .my_mac           (my_mac),
      .my_ip            (my_ip),
      .my_udp_chdr_port (my_udp_chdr_port),
      .active_slot      (active_slot),
      .addr_update      (addr_update)
   );

   always #5 bus_clk = ~bus_clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: live slots drive my_*, staged slots are what register reads see
   logic [47:0] m_mac [NS];
   logic [31:0] m_ip  [NS];
   logic [15:0] m_udp [NS];
   logic [47:0] s_mac [NS];
   logic [31:0] s_ip  [NS];
   logic [15:0] s_udp [NS];
   int          m_act;
   int          m_cnt [NC];
   logic [47:0] e_mac;
   logic [31:0] e_ip;
   logic [15:0] e_udp;
   logic        e_upd;
   logic        e_resp;
   logic [31:0] e_data;

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) begin
         m_mac[i] = D_MAC; m_ip[i] = D_IP; m_udp[i] = D_UDP;
         s_mac[i] = D_MAC; s_ip[i] = D_IP; s_udp[i] = D_UDP;
      end
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_act = 0;
      e_mac = D_MAC; e_ip = D_IP; e_udp = D_UDP;
      e_upd = 1'b0; e_resp = 1'b0; e_data = '0;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      int s;
      if (a % 4 != 0) return 32'h0;
      if (a < NS * 16) begin
         s = a / 16;
         case ((a % 16) / 4)
            0:       return s_mac[s][31:0];
            1:       return {16'h0, s_mac[s][47:32]};
            2:       return s_ip[s];
            default: return {16'h0, s_udp[s]};
         endcase
      end
      if (a == NS * 16) return 32'(m_act);
      if (a >= NS * 16 + 8 && a < NS * 16 + 8 + 4 * NC) return 32'(m_cnt[(a - NS * 16 - 8) / 4]);
      return 32'h0;
   endfunction

   task automatic model_step();
      int ra, wa, s;
      logic [47:0] o_mac;
      logic [31:0] o_ip;
      logic [15:0] o_udp;
      ra = int'(reg_rd_addr);
      wa = int'(reg_wr_addr);
      e_resp = reg_rd_req;
      e_data = reg_rd_req ? model_read(ra) : 32'h0;
      for (int i = 0; i < NC; i++) begin
         if (reg_rd_req && ra == NS * 16 + 8 + 4 * i) m_cnt[i] = cnt_evt[i] ? 1 : 0;
         else if (cnt_evt[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
      if (reg_wr_req && wa % 4 == 0) begin
         if (wa < NS * 16) begin
            s = wa / 16;
            case ((wa % 16) / 4)
               0:       s_mac[s][31:0]  = reg_wr_data;
               1:       s_mac[s][47:32] = reg_wr_data[15:0];
               2:       s_ip[s]         = reg_wr_data;
               default: s_udp[s]        = reg_wr_data[15:0];
            endcase
`ifndef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
            m_mac[s] = s_mac[s]; m_ip[s] = s_ip[s]; m_udp[s] = s_udp[s];
`endif
         end else if (wa == NS * 16) begin
            if (reg_wr_data < 32'(NS)) m_act = int'(reg_wr_data);
         end else if (wa == NS * 16 + 4) begin
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
            for (int i = 0; i < NS; i++) begin
               if (reg_wr_data[i]) begin
                  m_mac[i] = s_mac[i]; m_ip[i] = s_ip[i]; m_udp[i] = s_udp[i];
               end
            end
`endif
         end
      end
      o_mac = e_mac; o_ip = e_ip; o_udp = e_udp;
      e_mac = m_mac[m_act]; e_ip = m_ip[m_act]; e_udp = m_udp[m_act];
      e_upd = (e_mac != o_mac) || (e_ip != o_ip) || (e_udp != o_udp);
   endtask

   task automatic tick();
      model_step();
      @(posedge bus_clk);
      #1;
      check("rd_resp", 64'(reg_rd_resp), 64'(e_resp));
      if (e_resp) check("rd_data", 64'(reg_rd_data), 64'(e_data));
      check("my_mac", 64'(my_mac), 64'(e_mac));
      check("my_ip", 64'(my_ip), 64'(e_ip));
      check("my_udp", 64'(my_udp_chdr_port), 64'(e_udp));
      check("active_slot", 64'(active_slot), 64'(m_act));
      check("addr_update", 64'(addr_update), 64'(e_upd));
      reg_wr_req = 1'b0;
      reg_rd_req = 1'b0;
      cnt_evt    = '0;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      reg_wr_req = 1'b1; reg_wr_addr = AWD'(a); reg_wr_data = d;
      tick();
      $display("WR  addr=%04h data=%08h my_mac=%012h upd=%0b", a, d, my_mac, addr_update);
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      reg_rd_req = 1'b1; reg_rd_addr = AWD'(a);
      tick();
      d = reg_rd_data;
      $display("RD  addr=%04h data=%08h resp=%0b", a, d, reg_rd_resp);
   endtask

   logic [31:0] rdat;
   logic [47:0] new_mac;

   initial begin
      bus_rst = 1'b1;
      reg_wr_req = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
      reg_rd_req = 1'b0; reg_rd_addr = '0; cnt_evt = '0;
      model_reset();
      repeat (3) @(negedge bus_clk);
      bus_rst = 1'b0;
      #1;
      check("rst_resp", 64'(reg_rd_resp), 64'd0);
      check("rst_data", 64'(reg_rd_data), 64'd0);
      check("rst_mac", 64'(my_mac), 64'(D_MAC));
      check("rst_ip", 64'(my_ip), 64'(D_IP));
      check("rst_udp", 64'(my_udp_chdr_port), 64'(D_UDP));
      check("rst_active", 64'(active_slot), 64'd0);
      check("rst_upd", 64'(addr_update), 64'd0);

      // Default MAC readback, response exactly one cycle after request
      rd(0, rdat);  check("mac_lsb_def", 64'(rdat), 64'h2f16c52f);
      rd(4, rdat);  check("mac_msb_def", 64'(rdat), 64'h00000080);
      tick();       check("resp_one_cycle", 64'(reg_rd_resp), 64'd0);

      // Slot 1 IP, switch active slot, out-of-range select ignored
      wr(16 + 8, 32'h0A000001);
      wr(32, 32'd1);
      check("ip_switch", 64'(my_ip), 64'h0A000001);
      check("upd_pulse", 64'(addr_update), 64'd1);
      tick();
      check("upd_single", 64'(addr_update), 64'd0);
      wr(32, 32'd5);
      check("active_ignore", 64'(active_slot), 64'd1);
      rd(32, rdat); check("active_rd", 64'(rdat), 64'd1);

      // Counter 0 saturation and clear-on-read
      rd(40, rdat);
      for (int i = 0; i < 300; i++) begin
         cnt_evt = 2'b01;
         tick();
      end
      rd(40, rdat); check("cnt0_sat", 64'(rdat), 64'd255);
      rd(40, rdat); check("cnt0_clr", 64'(rdat), 64'd0);

      // Counter 1: read clear coinciding with an event keeps the event
      rd(44, rdat);
      for (int i = 0; i < 7; i++) begin
         cnt_evt = 2'b10;
         tick();
      end
      cnt_evt = 2'b10;
      rd(44, rdat); check("cnt1_race", 64'(rdat), 64'd7);
      rd(44, rdat); check("cnt1_after", 64'(rdat), 64'd1);

      // Slot 0 MAC write: staged behind COMMIT when shadows exist
      wr(32, 32'd0);
      new_mac = {16'h0080, 32'h12345678};
      wr(0, 32'h12345678);
`ifdef ETH_IPV4_ADDR_ATOMIC_COMMIT_EN
      check("mac_staged", 64'(my_mac), 64'(D_MAC));
      wr(36, 32'd1);
      check("mac_commit", 64'(my_mac), 64'(new_mac));
      check("mac_commit_upd", 64'(addr_update), 64'd1);
`else
      check("mac_direct", 64'(my_mac), 64'(new_mac));
      check("mac_direct_upd", 64'(addr_update), 64'd1);
      wr(0, 32'h12345678);
      check("mac_same_noupd", 64'(addr_update), 64'd0);
`endif

      // Same-cycle write and read of one address returns the old value
      reg_rd_req = 1'b1; reg_rd_addr = AWD'(8);
      reg_wr_req = 1'b1; reg_wr_addr = AWD'(8); reg_wr_data = 32'hCAFEF00D;
      tick();
      check("rw_same_old", 64'(reg_rd_data), 64'(D_IP));

      // Unmapped and COMMIT reads respond with zero
      rd(16'h100, rdat); check("unmapped", 64'(rdat), 64'd0);
      check("unmapped_resp", 64'(reg_rd_resp), 64'd1);
      rd(36, rdat);      check("commit_rd", 64'(rdat), 64'd0);

      // Randomized traffic against the model
      for (int it = 0; it < 600; it++) begin
         int r;
         reg_wr_req = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 11);
         reg_wr_data = $urandom;
         if (r < 8)       reg_wr_addr = AWD'($urandom_range(0, NS * 4 - 1) * 4);
         else if (r == 8) begin reg_wr_addr = AWD'(32); reg_wr_data = $urandom_range(0, 3); end
         else if (r == 9) begin reg_wr_addr = AWD'(36); reg_wr_data = $urandom_range(0, 3); end
         else             reg_wr_addr = AWD'($urandom_range(0, 16383));
         reg_rd_req = ($urandom_range(0, 1) == 0);
         r = $urandom_range(0, 15);
         if (r < 13) reg_rd_addr = AWD'($urandom_range(0, 13) * 4);
         else        reg_rd_addr = AWD'($urandom_range(0, 16383));
         cnt_evt = NC'($urandom_range(0, 3));
         $display("RND it=%0d wr=%0b a=%04h d=%08h rd=%0b a=%04h evt=%0b",
                  it, reg_wr_req, reg_wr_addr, reg_wr_data, reg_rd_req, reg_rd_addr, cnt_evt);
         tick();
      end

      // Async reset while a read is pending drops the response
      wr(32, 32'd1);
      reg_rd_req = 1'b1; reg_rd_addr = AWD'(0);
      #3 bus_rst = 1'b1;
      #1;
      check("arst_active", 64'(active_slot), 64'd0);
      check("arst_mac", 64'(my_mac), 64'(D_MAC));
      @(posedge bus_clk); #1;
      check("arst_noresp", 64'(reg_rd_resp), 64'd0);
      @(negedge bus_clk);
      bus_rst = 1'b0; reg_rd_req = 1'b0;
      model_reset();

      // Async reset while the response is already high clears it at once
      cnt_evt = 2'b01;
      tick();
      rd(0, rdat);
      #2 bus_rst = 1'b1;
      #1;
      check("arst_resp_drop", 64'(reg_rd_resp), 64'd0);
      check("arst_data_zero", 64'(reg_rd_data), 64'd0);
      @(negedge bus_clk);
      bus_rst = 1'b0;
      model_reset();
      rd(40, rdat); check("arst_cnt_zero", 64'(rdat), 64'd0);
      rd(4, rdat);  check("arst_mac_msb", 64'(rdat), 64'h00000080);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
